// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// A grant is held for bursts of up to BURST_LEN beats to keep packets from one source together.
module fifo_write_arbiter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ID_WIDTH   = 2,
  parameter  int BURST_LEN  = 4,
  localparam int NUM_REQ    = 1 << ID_WIDTH,
  localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                          clock_write,
  input  logic                          write_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          write_enable,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          o_dbg_state,
  output logic [CNT_W-1:0]              o_dbg_beat_cnt
);

  // Handshake: word i moves into the FIFO in any cycle where req_valid[i] and
  // req_ready[i] are both high at the rising edge; ready never depends on the
  // other requesters' valid, and a requester may drop valid before ready.

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state, w_next_state;
  logic [ID_WIDTH-1:0] r_grant_id, w_next_grant;
  logic [ID_WIDTH-1:0] r_last_grant, w_next_last;
  logic [CNT_W-1:0]    r_beat_cnt, w_next_beat;

  logic                w_cur_valid;
  logic                w_xfer;
  logic                w_burst_end;
  logic                w_release;
  logic                w_any_valid;
  logic [ID_WIDTH-1:0] w_base;
  logic [ID_WIDTH-1:0] w_pick;

  // Scan base+1 .. base+NUM_REQ; base itself is checked last, so it wins only
  // when it is the sole valid requester.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [ID_WIDTH-1:0] base,
                                                  input logic [NUM_REQ-1:0]  valid);
    logic [ID_WIDTH-1:0] pick;
    logic [ID_WIDTH-1:0] idx;
    pick = base;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = base + ID_WIDTH'(k);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign w_cur_valid = req_valid[r_grant_id];
  assign w_xfer      = (r_state == S_GRANT) & w_cur_valid & ~full;
  assign w_burst_end = w_xfer & (r_beat_cnt == CNT_W'(BURST_LEN - 1));
  assign w_release   = (r_state == S_GRANT) & (w_burst_end | ~w_cur_valid);
  assign w_any_valid = |req_valid;
  assign w_base      = (r_state == S_GRANT) ? r_grant_id : r_last_grant;
  assign w_pick      = rr_pick(w_base, req_valid);

  always_ff @(posedge clock_write) begin
    if (write_reset) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_grant_id   <= w_next_grant;
      r_last_grant <= w_next_last;
      r_beat_cnt   <= w_next_beat;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant_id;
    w_next_last  = r_last_grant;
    w_next_beat  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_next_grant = w_pick;
          w_next_beat  = '0;
          w_next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_xfer) w_next_beat = r_beat_cnt + CNT_W'(1);
        // Re-arbitrate in the same cycle so back-to-back grants have no bubble.
        if (w_release) begin
          w_next_last = r_grant_id;
          w_next_beat = '0;
          if (w_any_valid) w_next_grant = w_pick;
          else             w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign write_enable   = w_xfer & ~write_reset;
  assign req_ready      = write_enable ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign write_data     = ((r_state == S_GRANT) && !write_reset) ?
                          req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy           = (r_state == S_GRANT) & ~write_reset;
  assign grant_id       = r_grant_id;
  assign o_dbg_state    = (r_state == S_GRANT);
  assign o_dbg_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-source word queues checked by a negedge monitor,
// plus expected grant sequences for the directed scenarios and a randomized soak.
module tb_fifo_write_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          full;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [1:0]    grant_id;
  logic          busy;
  logic          dbg_state;
  logic [1:0]    dbg_beat;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_write_arbiter #(.DATA_WIDTH(16), .ID_WIDTH(2), .BURST_LEN(4)) dut (
    .clock_write    (clk),
    .write_reset    (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .full           (full),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .grant_id       (grant_id),
    .busy           (busy),
    .o_dbg_state    (dbg_state),
    .o_dbg_beat_cnt (dbg_beat)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[NR][$];   // words each source has issued but not yet seen written
  logic [1:0]    log_q[$];       // source id of every observed write
  int            wcyc_q[$];      // cycle of every observed write
  logic [1:0]    exp_log[$];     // expected write order for a directed scenario

  // source model
  int            src_left[NR];
  logic [NR-1:0] have;
  logic [NR-1:0] gate;
  logic [DW-1:0] cur[NR];
  logic [DW-1:0] nxt[NR];

  logic [3:0] mon_oh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_we", 32'(write_enable), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
    end else begin
      if (write_enable) begin
        mon_oh = 4'b0001 << grant_id;
        check("we_while_full", 32'(full), 0);
        check("ready_onehot", 32'(req_ready), 32'(mon_oh));
        if (exp_q[grant_id].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: src %0d data %0h with nothing pending", grant_id, write_data);
        end else begin
          check("write_data", 32'(write_data), 32'(exp_q[grant_id].pop_front()));
        end
        log_q.push_back(grant_id);
        wcyc_q.push_back(cyc);
      end else begin
        check("ready_no_write", 32'(req_ready), 0);
      end
      if (!busy) check("wdata_idle", 32'(write_data), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      if (!have[i] && src_left[i] > 0) begin
        cur[i] = nxt[i];
        nxt[i] = nxt[i] + 16'd1;
        src_left[i]--;
        have[i] = 1'b1;
        exp_q[i].push_back(cur[i]);
      end
      req_data[i*DW +: DW] = have[i] ? cur[i] : 16'($urandom);
      req_valid[i] = have[i] & gate[i];
    end
  endtask

  task automatic tick();
    logic [NR-1:0] rs;
    @(negedge clk);
    rs = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (rs[i]) have[i] = 1'b0;
    apply();
  endtask

  task automatic start(input int i, input int n, input logic [DW-1:0] base, input logic g);
    src_left[i] = n;
    nxt[i]      = base;
    gate[i]     = g;
  endtask

  function automatic logic pending();
    logic p = (have != '0);
    for (int i = 0; i < NR; i++) if (src_left[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain();
    int b = 600;
    while (pending() && b > 0) begin
      tick();
      b--;
    end
    check("drain_done", 32'(pending()), 0);
    tick();
    tick();
  endtask

  task automatic wait_log(input int n);
    int b = 50;
    while (log_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    check("wait_writes", 32'(log_q.size() >= n), 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    wcyc_q.delete();
    exp_log.delete();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(log_q.size()), 32'(exp_log.size()));
    for (int k = 0; k < exp_log.size() && k < log_q.size(); k++)
      check(name, 32'(log_q[k]), 32'(exp_log[k]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int b;
    rst = 1'b1;
    full = 1'b0;
    have = '0;
    gate = '0;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      src_left[i] = 0;
      cur[i] = '0;
      nxt[i] = '0;
    end

    // 1: reset held three cycles with every source valid
    for (int i = 0; i < NR; i++) start(i, 1, 16'(16'h1000 * (i + 1)), 1'b1);
    apply();
    repeat (3) begin
      tick();
      #1;
      check("t1_grant_id", 32'(grant_id), 0);
      check("t1_we", 32'(write_enable), 0);
      check("t1_ready", 32'(req_ready), 0);
      check("t1_busy", 32'(busy), 0);
    end
    rst = 1'b0;
    clear_logs();
    drain();
    for (int i = 0; i < NR; i++) exp_log.push_back(2'(i));
    check_log("t1_order");

    // 2: single source streams ten words, bursts 4/4/2 with no gaps
    clear_logs();
    start(2, 10, 16'h0001, 1'b1);
    apply();
    t0 = cyc;
    drain();
    repeat (10) exp_log.push_back(2'd2);
    check_log("t2_order");
    check("t2_first_cycle", 32'(wcyc_q.size() > 0 ? wcyc_q[0] : -1), 32'(t0 + 1));
    check("t2_last_cycle", 32'(wcyc_q.size() > 9 ? wcyc_q[9] : -1), 32'(t0 + 10));

    // 3: all four sources continuously valid
    reset_pulse();
    clear_logs();
    for (int i = 0; i < NR; i++) start(i, 8, 16'(i * 256), 1'b1);
    apply();
    t0 = cyc;
    drain();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        repeat (4) exp_log.push_back(2'(i));
    check_log("t3_order");
    check("t3_first_cycle", 32'(wcyc_q.size() > 0 ? wcyc_q[0] : -1), 32'(t0 + 1));
    check("t3_span", 32'(wcyc_q.size() > 31 ? wcyc_q[31] - wcyc_q[0] : -1), 31);

    // 4: full asserted for seven cycles after two beats of source 1
    reset_pulse();
    clear_logs();
    start(1, 8, 16'h1100, 1'b1);
    start(2, 4, 16'h2200, 1'b1);
    apply();
    wait_log(2);
    full = 1'b1;
    repeat (7) begin
      #1;
      check("t4_we", 32'(write_enable), 0);
      check("t4_grant", 32'(grant_id), 1);
      check("t4_beat", 32'(dbg_beat), 2);
      check("t4_busy", 32'(busy), 1);
      tick();
    end
    full = 1'b0;
    drain();
    repeat (4) exp_log.push_back(2'd1);
    repeat (4) exp_log.push_back(2'd2);
    repeat (4) exp_log.push_back(2'd1);
    check_log("t4_order");

    // 5: source 3 drops valid after one beat, grant wraps to 0
    reset_pulse();
    clear_logs();
    start(3, 5, 16'h3300, 1'b1);
    start(0, 3, 16'h0A00, 1'b0);
    apply();
    wait_log(1);
    gate[3] = 1'b0;
    gate[0] = 1'b1;
    apply();
    tick();
    #1;
    check("t5_wrap_grant", 32'(grant_id), 0);
    check("t5_wrap_busy", 32'(busy), 1);
    b = 50;
    while ((have[0] || src_left[0] > 0) && b > 0) begin
      tick();
      b--;
    end
    check("t5_src0_done", 32'(have[0] || src_left[0] > 0), 0);
    gate[3] = 1'b1;
    apply();
    drain();
    exp_log.push_back(2'd3);
    repeat (3) exp_log.push_back(2'd0);
    repeat (4) exp_log.push_back(2'd3);
    check_log("t5_order");

    // 6: reset during source 2 beat 1
    reset_pulse();
    clear_logs();
    start(2, 6, 16'h5500, 1'b1);
    start(0, 2, 16'h0B00, 1'b0);
    apply();
    wait_log(1);
    rst = 1'b1;
    tick();
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_grant", 32'(grant_id), 0);
    check("t6_state", 32'(dbg_state), 0);
    rst = 1'b0;
    gate[0] = 1'b1;
    apply();
    tick();
    #1;
    check("t6_first_grant", 32'(grant_id), 0);
    check("t6_first_busy", 32'(busy), 1);
    drain();
    exp_log.push_back(2'd2);
    repeat (2) exp_log.push_back(2'd0);
    repeat (5) exp_log.push_back(2'd2);
    check_log("t6_order");

    // 7: randomized valid gating and full back-pressure
    reset_pulse();
    clear_logs();
    for (int i = 0; i < NR; i++)
      start(i, $urandom_range(10, 30), 16'($urandom), 1'b1);
    apply();
    b = 2000;
    while (pending() && b > 0) begin
      tick();
      for (int i = 0; i < NR; i++) gate[i] = ($urandom_range(0, 4) != 0);
      full = ($urandom_range(0, 3) == 0);
      apply();
      b--;
    end
    gate = '1;
    full = 1'b0;
    apply();
    drain();
    for (int i = 0; i < NR; i++) check("leftover_words", 32'(exp_q[i].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
